pcie_rx_deframer: RTL
=====================

# pcie_rx_deframer

Receive-side data-link deframer sitting directly downstream of `PCIE_PHY`. It consumes the PHY's byte stream (`DATA_OUT`/`CONTROL_OUT`), recognises STP…END framed packets, checks length and XOR checksum, and buffers payload store-and-forward. Only fully validated frames are released to the transaction layer over a valid/ready byte stream. Bad frames are discarded and flagged on `ERROR_DLL`.

## Interface
- `FIFO_DEPTH`, default 16: payload buffer entries; must be a power of 2.
- `MAX_LEN`, default 8: largest legal payload length in bytes; must satisfy MAX_LEN ≤ FIFO_DEPTH.
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `VALID_IN`  in  1  DATA_IN/CONTROL_IN carry a symbol this cycle.
- `DATA_IN`  in  8  byte from PHY `DATA_OUT`.
- `CONTROL_IN`  in  8  from PHY `CONTROL_OUT`. 8'h00 means a data byte. Nonzero is a control symbol code: STP=8'hFB, END=8'hFD, COM=8'hBC; any other nonzero value is "other control".
- `PKT_READY`  in  1  consumer accepts the head byte.
- `PKT_VALID`  out  1  head byte available.
- `PKT_DATA`  out  8  head payload byte.
- `PKT_LAST`  out  1  head byte is the last byte of its frame.
- `FRAME_OK`  out  1  one-cycle pulse: a frame was committed.
- `ERROR_DLL`  out  1  one-cycle pulse: a frame was discarded.
- `ERR_COUNT`  out  8  count of discarded frames; saturates at 8'hFF.

## Operation
- **Buffer:** FIFO_DEPTH × 9-bit RAM holding {last, data}.
  - Three pointers, each log2(FIFO_DEPTH)+1 bits: `wr_spec` (speculative write), `wr_commit`, `rd`.
  - free = FIFO_DEPTH − (wr_spec − rd).
- **Commit:** set wr_commit ← wr_spec.
- **Rollback:** set wr_spec ← wr_commit. Every error performs a rollback.
- **Cycles with VALID_IN=0:** the FSM holds state; gaps are legal anywhere in a frame.
- **FSM states:** IDLE, LEN, PAYLOAD, CHK, ENDW.
  - **IDLE:** on STP, go to LEN. Data bytes, COM and other symbols are ignored.
  - **LEN:** on a data byte L:
    - If L=0, L>MAX_LEN or L>free: error, go to IDLE.
    - Otherwise latch L, clear cnt and xor, go to PAYLOAD.
  - **PAYLOAD:** on a data byte:
    - Write {cnt==L−1, byte} at wr_spec; increment wr_spec and cnt; xor ^= byte.
    - On the last byte, go to CHK.
  - **CHK:** on a data byte, set bad ← (byte ≠ xor) and go to ENDW.
  - **ENDW:** on END:
    - If !bad: commit and pulse FRAME_OK.
    - If bad: error (rollback).
    - Go to IDLE.
  - **Aborts in LEN/PAYLOAD/CHK/ENDW:**
    - STP: error, go to LEN (a new frame starts at that STP).
    - COM, END or other control in LEN/PAYLOAD/CHK: error, go to IDLE.
    - Data byte in ENDW: error, go to IDLE.
- **Error effects:** rollback, ERROR_DLL pulse, and ERR_COUNT increments (saturating at 8'hFF).
- **Read side:** first-word-fall-through.
  - PKT_VALID = (rd ≠ wr_commit); PKT_DATA/PKT_LAST reflect RAM[rd].
  - On PKT_VALID & PKT_READY, rd increments.
  - While PKT_VALID & !PKT_READY, PKT_DATA/PKT_LAST hold stable.
- **Simultaneous events:** a read and a commit in the same cycle are both honoured. The free check uses the rd value registered before the LEN byte's edge.

## Timing
- **Reset (asynchronous):**
  - State goes to IDLE; all pointers, cnt, xor and bad clear to 0.
  - Outputs: PKT_VALID=0, PKT_DATA=0, PKT_LAST=0, FRAME_OK=0, ERROR_DLL=0, ERR_COUNT=0.
  - Committed and uncommitted data are lost.
- **FRAME_OK/ERROR_DLL:** registered; high exactly one cycle, in the cycle after the edge that samples the terminating symbol.
- **Release latency:** committed data shows PKT_VALID in the same cycle as FRAME_OK, i.e. one cycle after END is sampled. Minimum input-to-output latency is L+3 accepted symbols plus 1 cycle.
- **Throughput:** one input symbol per cycle; one output byte per cycle.
- **Backpressure:** there is no input backpressure. Frames that do not fit are dropped at the LEN byte.

## Test plan
1. STP, 8'h03, A1, B2, C3, chk D0, END → FRAME_OK pulses one cycle after END. With PKT_READY=1, output is A1, B2, C3 with PKT_LAST only on C3. ERR_COUNT=0.
2. Same frame with chk D1 → ERROR_DLL pulse, PKT_VALID stays 0, ERR_COUNT=1. A following good frame (02, 11, 22, chk 33) is delivered intact.
3. Length 8'h00, then length 8'h09 (MAX_LEN=8) → two ERROR_DLL pulses, ERR_COUNT=2, nothing buffered.
4. STP, 04, 01, 02, then STP, 01, 5A, 5A, END → one ERROR_DLL on the second STP. FRAME_OK follows; output is the single byte 5A with PKT_LAST=1.
5. Hold PKT_READY=0 and send two good 8-byte frames (buffer full, free=0). A third frame with L=1 → ERROR_DLL. Releasing PKT_READY drains 16 bytes in order with LAST on bytes 8 and 16. ERR_COUNT saturation is checked separately by forcing 256 errors, which leaves ERR_COUNT=FF.
6. Assert RESET mid-PAYLOAD with one committed frame pending → all outputs go to 0 immediately. A fresh good frame after release is delivered normally.

Source files
------------

// File: rtl/pcie_rx_deframer.sv
// ---------------------------------------------------------------------------
// pcie_rx_deframer
//
// Receive-side data-link deframer. Parses STP / LEN / payload / CHK / END
// frames from the PHY symbol stream, checks the length and the XOR checksum,
// and buffers the payload store-and-forward. Payload bytes are written
// speculatively and only become visible to the reader once the whole frame
// has been validated. A frame that fails is rolled back and reported.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   VALID_IN            DATA_IN / CONTROL_IN carry a symbol this cycle
//   DATA_IN[7:0]        symbol byte
//   CONTROL_IN[7:0]     00 = data, FB = STP, FD = END, other = control
//   PKT_READY           consumer takes the head byte
//   PKT_VALID           head byte available (first-word-fall-through)
//   PKT_DATA[7:0]       head payload byte
//   PKT_LAST            head byte closes its frame
//   FRAME_OK            one-cycle pulse, frame committed
//   ERROR_DLL           one-cycle pulse, frame discarded
//   ERR_COUNT[7:0]      discarded frame count, saturating
// ---------------------------------------------------------------------------
module pcie_rx_deframer #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VALID_IN,
    input  logic [7:0] DATA_IN,
    input  logic [7:0] CONTROL_IN,
    input  logic       PKT_READY,
    output logic       PKT_VALID,
    output logic [7:0] PKT_DATA,
    output logic       PKT_LAST,
    output logic       FRAME_OK,
    output logic       ERROR_DLL,
    output logic [7:0] ERR_COUNT
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0] SYM_STP   = 8'hFB;
    localparam logic [7:0] SYM_END   = 8'hFD;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [AW:0] DEPTH_P  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_ENDW
    } state_t;

    state_t      state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_spec_q, wr_spec_d;
    logic [AW:0] wr_commit_q, wr_commit_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  xor_q, xor_d;
    logic        bad_q, bad_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [7:0]  errcnt_q, errcnt_d;

    logic [8:0]  mem_q [FIFO_DEPTH];

    // Symbol decode. COM falls into the generic "control" class.
    logic is_data, is_ctl, is_stp, is_end;
    assign is_data = VALID_IN && (CONTROL_IN == 8'h00);
    assign is_ctl  = VALID_IN && (CONTROL_IN != 8'h00);
    assign is_stp  = VALID_IN && (CONTROL_IN == SYM_STP);
    assign is_end  = VALID_IN && (CONTROL_IN == SYM_END);

    // Space left in the buffer. At the LEN byte no speculative data is
    // outstanding, so this is the room left behind committed, unread bytes.
    logic [AW:0] used, free;
    logic        len_bad;
    logic        last_byte;
    assign used      = wr_spec_q - rd_q;
    assign free      = DEPTH_P - used;
    assign len_bad   = (DATA_IN == 8'h00) || (DATA_IN > MAX_LEN_B) ||
                       ({8'h00, DATA_IN} > 16'(free));
    assign last_byte = (cnt_q == (len_q - 8'd1));

    // FSM outputs
    logic wr_en, commit, err, len_ld, chk_ld;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next state ----------------
    // A new STP anywhere inside a frame restarts parsing at LEN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_stp) state_d = S_LEN;
            end
            S_LEN: begin
                if (is_stp)       state_d = S_LEN;
                else if (is_ctl)  state_d = S_IDLE;
                else if (is_data) state_d = len_bad ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (is_stp)                    state_d = S_LEN;
                else if (is_ctl)               state_d = S_IDLE;
                else if (is_data && last_byte) state_d = S_CHK;
            end
            S_CHK: begin
                if (is_stp)       state_d = S_LEN;
                else if (is_ctl)  state_d = S_IDLE;
                else if (is_data) state_d = S_ENDW;
            end
            S_ENDW: begin
                // COM / other control while waiting for END is ignored.
                if (is_stp)                 state_d = S_LEN;
                else if (is_end || is_data) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        err    = 1'b0;
        len_ld = 1'b0;
        chk_ld = 1'b0;
        unique case (state_q)
            S_LEN: begin
                if (is_ctl)       err = 1'b1;
                else if (is_data) begin
                    if (len_bad) err    = 1'b1;
                    else         len_ld = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (is_ctl)       err   = 1'b1;
                else if (is_data) wr_en = 1'b1;
            end
            S_CHK: begin
                if (is_ctl)       err    = 1'b1;
                else if (is_data) chk_ld = 1'b1;
            end
            S_ENDW: begin
                if (is_stp || is_data) err = 1'b1;
                else if (is_end) begin
                    if (bad_q) err    = 1'b1;
                    else       commit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        rd_d        = rd_q + ((PKT_VALID && PKT_READY) ? 1'b1 : 1'b0);
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        bad_d       = bad_q;
        errcnt_d    = errcnt_q;
        ok_d        = commit;
        err_d       = err;

        if (err)        wr_spec_d = wr_commit_q;   // rollback
        else if (wr_en) wr_spec_d = wr_spec_q + 1'b1;

        if (commit) wr_commit_d = wr_spec_q;

        if (len_ld) begin
            len_d = DATA_IN;
            cnt_d = 8'h00;
            xor_d = 8'h00;
        end else if (wr_en) begin
            cnt_d = cnt_q + 8'd1;
            xor_d = xor_q ^ DATA_IN;
        end

        if (chk_ld) bad_d = (DATA_IN != xor_q);

        if (err && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            len_q       <= 8'h00;
            cnt_q       <= 8'h00;
            xor_q       <= 8'h00;
            bad_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            errcnt_q    <= 8'h00;
        end else begin
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_q        <= rd_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            bad_q       <= bad_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            errcnt_q    <= errcnt_d;
        end
    end

    // Payload RAM. The LEN-time free check guarantees a speculative write
    // never lands on a committed, unread entry, so the head stays stable.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_spec_q[AW-1:0]] <= {last_byte, DATA_IN};
    end

    // ---------------- read side ----------------
    // Head is gated by PKT_VALID so the outputs read zero out of reset
    // regardless of RAM contents.
    logic [8:0] head;
    assign head      = mem_q[rd_q[AW-1:0]];
    assign PKT_VALID = (rd_q != wr_commit_q);
    assign PKT_DATA  = PKT_VALID ? head[7:0] : 8'h00;
    assign PKT_LAST  = PKT_VALID && head[8];
    assign FRAME_OK  = ok_q;
    assign ERROR_DLL = err_q;
    assign ERR_COUNT = errcnt_q;

endmodule
